// File: rtl/dualportram_sync_pkg.sv
// Shared types and helpers for the dualportram_sync block.
//   clr_state_t : post-reset clear sequencer states (CLEAR, RUN)
//   RDW_OLD/NEW : read-during-write selections for the RDW_MODE parameter
//   lane_count  : number of byte-enable lanes in a word
package dualportram_sync_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dualportram_sync_if.sv
// Bus bundle for dualportram_sync: one write port, one read port and status.
//   master : drives wr_cs/we/be/wr_address/din and rd_cs/oe/rd_address,
//            observes dout/dout_valid/ready
//   slave  : the RAM side of the same signals
interface dualportram_sync_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BYTE_WIDTH    = 8
);
  import dualportram_sync_pkg::*;

  localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);

  logic                     wr_cs;
  logic                     we;
  logic [LANES-1:0]         be;
  logic [ADDRESS_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0]    din;
  logic                     rd_cs;
  logic                     oe;
  logic [ADDRESS_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0]    dout;
  logic                     dout_valid;
  logic                     ready;

  modport master (
    output wr_cs, we, be, wr_address, din, rd_cs, oe, rd_address,
    input  dout, dout_valid, ready
  );

  modport slave (
    input  wr_cs, we, be, wr_address, din, rd_cs, oe, rd_address,
    output dout, dout_valid, ready
  );

endinterface

// File: rtl/dualportram_clear_fsm.sv
// Post-reset clear sequencer: walks every word address once, asking the RAM
// to write zero there, then raises ready and stays in RUN until reset.
//   clk, rst     : clock, asynchronous active-high reset
//   o_ready      : clear complete, user traffic may be accepted
//   o_clr_we     : clear write strobe (high for the whole CLEAR state)
//   o_clr_addr   : word currently being cleared
module dualportram_clear_fsm
  import dualportram_sync_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 2**ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     o_ready,
  output logic                     o_clr_we,
  output logic [ADDRESS_WIDTH-1:0] o_clr_addr
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);

  clr_state_t               r_state;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                     r_ready;

  // The counter stops on the last word rather than wrapping, so DEPTH equal
  // to the full address space never overflows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == CLEAR) begin
      if (r_cnt == LAST) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + ADDRESS_WIDTH'(1);
      end
    end else begin
      r_ready <= 1'b1;
    end
  end

  assign o_ready    = r_ready;
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/dualportram_sync.sv
// Simple dual-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, range checking and a post-reset clear.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dualportram_sync_if.slave (write port, read port, dout,
//              dout_valid, ready)
// Optional build macro DUALPORTRAM_SYNC_OUTREG_EN adds an output register
// stage (read latency 2, dout_valid kept aligned).
module dualportram_sync
  import dualportram_sync_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 2**ADDRESS_WIDTH,
  parameter int BYTE_WIDTH    = 8,
  parameter int RDW_MODE      = RDW_OLD
) (
  input logic              clk,
  input logic              rst,
  dualportram_sync_if.slave bus
);

  localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic                     w_ready;
  logic                     w_clr_we;
  logic [ADDRESS_WIDTH-1:0] w_clr_addr;
  logic                     w_wr_in;
  logic                     w_rd_in;
  logic                     w_wr_en;
  logic                     w_rd_en;
  logic                     w_fwd;
  logic [DATA_WIDTH-1:0]    w_rd_old;
  logic [DATA_WIDTH-1:0]    w_rd_word;
  logic [DATA_WIDTH-1:0]    r_dout_p0;
  logic                     r_vld_p0;

  dualportram_clear_fsm #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_wr_in = {1'b0, bus.wr_address} < DEPTH_L;
  assign w_rd_in = {1'b0, bus.rd_address} < DEPTH_L;
  assign w_wr_en = w_ready && bus.wr_cs && bus.we && w_wr_in;
  assign w_rd_en = w_ready && bus.rd_cs && bus.oe;

  // Out-of-range reads return zero; forwarding only applies when the write
  // actually lands on the word being read.
  assign w_rd_old  = w_rd_in ? r_mem[bus.rd_address] : '0;
  assign w_fwd     = (RDW_MODE == RDW_NEW) && w_wr_en && (bus.wr_address == bus.rd_address);
  assign w_rd_word = w_fwd ? merge_lanes(w_rd_old, bus.din, bus.be) : w_rd_old;

  // Clear writes own the array until ready; user writes are gated by ready.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.wr_address] <= merge_lanes(r_mem[bus.wr_address], bus.din, bus.be);
    end
  end

  // ---- stage p0: array read ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_p0 <= '0;
      r_vld_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd_en;
      if (w_rd_en) r_dout_p0 <= w_rd_word;
    end
  end

`ifdef DUALPORTRAM_SYNC_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_dout_p1;
  logic                  r_vld_p1;

  // ---- stage p1: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_dout_p1 <= r_dout_p0;
      r_vld_p1  <= r_vld_p0;
    end
  end

  assign bus.dout       = r_dout_p1;
  assign bus.dout_valid = r_vld_p1;
`else
  assign bus.dout       = r_dout_p0;
  assign bus.dout_valid = r_vld_p0;
`endif

  assign bus.ready = w_ready;

endmodule

// File: tb/tb_dualportram_sync.sv
// Bench for dualportram_sync: two instances (8-bit/256 words/old-data and
// 32-bit/200 words/new-data) driven against a behavioural array model.
module tb_dualportram_sync;
`ifdef DUALPORTRAM_SYNC_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DA = 256;
  localparam int DB = 200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dualportram_sync_if #(.DATA_WIDTH(8),  .ADDRESS_WIDTH(8), .BYTE_WIDTH(8)) ifA ();
  dualportram_sync_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .BYTE_WIDTH(8)) ifB ();

  dualportram_sync #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .DEPTH(DA), .BYTE_WIDTH(8), .RDW_MODE(0))
    dutA (.clk(clk), .rst(rst), .bus(ifA));
  dualportram_sync #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .DEPTH(DB), .BYTE_WIDTH(8), .RDW_MODE(1))
    dutB (.clk(clk), .rst(rst), .bus(ifB));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word arrays, clear progress, and a read pipeline.
  logic [7:0]  memA [DA];
  logic [31:0] memB [DB];
  int          clrA, clrB;
  bit          rdyA, rdyB;
  logic [31:0] dA [2];
  logic [31:0] dB [2];
  bit          vA [2];
  bit          vB [2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be, input int lanes);
    for (int i = 0; i < lanes; i++) if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    return o;
  endfunction

  task automatic model_reset();
    clrA = 0; clrB = 0; rdyA = 0; rdyB = 0;
    for (int i = 0; i < 2; i++) begin dA[i] = '0; dB[i] = '0; vA[i] = 0; vB[i] = 0; end
  endtask

  task automatic model_edge();
    logic [31:0] old;
    int ra, wa;
    if (!rst) begin
      dA[1] = dA[0]; vA[1] = vA[0]; dB[1] = dB[0]; vB[1] = vB[0];
      if (!rdyA) begin
        memA[clrA] = '0; clrA++; rdyA = (clrA == DA); vA[0] = 0;
      end else begin
        ra = int'(ifA.rd_address); wa = int'(ifA.wr_address);
        vA[0] = ifA.rd_cs && ifA.oe;
        if (vA[0]) dA[0] = (ra < DA) ? {24'b0, memA[ra]} : 32'b0;
        if (ifA.wr_cs && ifA.we && wa < DA) begin
          old = merge({24'b0, memA[wa]}, {24'b0, ifA.din}, {3'b0, ifA.be}, 1);
          memA[wa] = old[7:0];
        end
      end
      if (!rdyB) begin
        memB[clrB] = '0; clrB++; rdyB = (clrB == DB); vB[0] = 0;
      end else begin
        ra = int'(ifB.rd_address); wa = int'(ifB.wr_address);
        vB[0] = ifB.rd_cs && ifB.oe;
        if (vB[0]) begin
          if (ra >= DB) dB[0] = '0;
          else begin
            old = memB[ra];
            if (ifB.wr_cs && ifB.we && wa == ra) old = merge(old, ifB.din, ifB.be, 4);
            dB[0] = old;
          end
        end
        if (ifB.wr_cs && ifB.we && wa < DB) memB[wa] = merge(memB[wa], ifB.din, ifB.be, 4);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    ifA.wr_cs = 0; ifA.we = 0; ifA.be = '0; ifA.wr_address = '0; ifA.din = '0;
    ifA.rd_cs = 0; ifA.oe = 0; ifA.rd_address = '0;
    ifB.wr_cs = 0; ifB.we = 0; ifB.be = '0; ifB.wr_address = '0; ifB.din = '0;
    ifB.rd_cs = 0; ifB.oe = 0; ifB.rd_address = '0;
  endtask

  task automatic wrA(input logic [7:0] a, input logic [7:0] d);
    ifA.wr_cs = 1; ifA.we = 1; ifA.be = 1'b1; ifA.wr_address = a; ifA.din = d;
  endtask
  task automatic wrB(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    ifB.wr_cs = 1; ifB.we = 1; ifB.be = be; ifB.wr_address = a; ifB.din = d;
  endtask
  task automatic rdA(input logic [7:0] a);
    ifA.rd_cs = 1; ifA.oe = 1; ifA.rd_address = a;
  endtask
  task automatic rdB(input logic [7:0] a);
    ifB.rd_cs = 1; ifB.oe = 1; ifB.rd_address = a;
  endtask

  // Issue the pending requests, then idle until the read result is visible.
  task automatic issue_and_wait();
    step();
    idle();
    repeat (LAT - 1) step();
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    if ({ifA.dout, ifA.dout_valid, ifA.ready} !== 10'b0) begin
      n_fail++; $display("FAIL reset_A: got %h/%b/%b want 00/0/0", ifA.dout, ifA.dout_valid, ifA.ready);
    end
    n_tests++;
    if ({ifB.dout, ifB.dout_valid, ifB.ready} !== 34'b0) begin
      n_fail++; $display("FAIL reset_B: got %h/%b/%b want 0/0/0", ifB.dout, ifB.dout_valid, ifB.ready);
    end
    n_tests++;
    rst = 0;
    for (int k = 1; k <= DA; k++) begin
      step();
      if ({ifA.ready, ifB.ready, ifA.dout_valid, ifB.dout_valid} !== {k >= DA, k >= DB, 2'b00}) begin
        n_fail++;
        $display("FAIL clear_timing edge %0d: got rdyA=%b rdyB=%b vA=%b vB=%b want rdyA=%b rdyB=%b v=0",
                 k, ifA.ready, ifB.ready, ifA.dout_valid, ifB.dout_valid, k >= DA, k >= DB);
      end
      n_tests++;
    end
  endtask

  task automatic test_clear_readback();
    for (int a = 0; a < DA + LAT; a++) begin
      idle();
      if (a < DA) begin rdA(8'(a)); rdB(8'(a)); end
      step();
      if ({ifA.dout, ifA.dout_valid} !== {dA[LAT-1][7:0], vA[LAT-1]} ||
          (a >= LAT && a < DA + LAT - 1 + LAT && ifA.dout !== 8'h00)) begin
        n_fail++; $display("FAIL readback_A %0d: got %h/%b want %h/%b", a, ifA.dout, ifA.dout_valid, dA[LAT-1][7:0], vA[LAT-1]);
      end
      n_tests++;
      if ({ifB.dout, ifB.dout_valid} !== {dB[LAT-1], vB[LAT-1]}) begin
        n_fail++; $display("FAIL readback_B %0d: got %h/%b want %h/%b", a, ifB.dout, ifB.dout_valid, dB[LAT-1], vB[LAT-1]);
      end
      n_tests++;
    end
    idle();
  endtask

  task automatic test_write_read();
    wrA(8'h10, 8'hA5); step(); idle();
    rdA(8'h10); issue_and_wait();
    if ({ifA.dout, ifA.dout_valid} !== {8'hA5, 1'b1}) begin
      n_fail++; $display("FAIL write_read: got %h/%b want a5/1", ifA.dout, ifA.dout_valid);
    end
    n_tests++;
    step();
    if ({ifA.dout, ifA.dout_valid} !== {8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL read_hold: got %h/%b want a5/0", ifA.dout, ifA.dout_valid);
    end
    n_tests++;
  endtask

  task automatic test_byte_lanes();
    wrB(8'h33, 32'h11223344, 4'hF); step();
    wrB(8'h33, 32'hAABBCCDD, 4'b0101); step();
    wrB(8'h33, 32'hFFFFFFFF, 4'b0000); step(); idle();
    rdB(8'h33); issue_and_wait();
    if ({ifB.dout, ifB.dout_valid} !== {32'h11BB33DD, 1'b1}) begin
      n_fail++; $display("FAIL byte_lanes: got %h/%b want 11bb33dd/1", ifB.dout, ifB.dout_valid);
    end
    n_tests++;
  endtask

  task automatic test_rdw();
    wrA(8'h20, 8'h5A); rdA(8'h20);
    wrB(8'h20, 32'h0000005A, 4'hF); rdB(8'h20);
    issue_and_wait();
    if ({ifA.dout, ifA.dout_valid} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL rdw_old: got %h/%b want 00/1", ifA.dout, ifA.dout_valid);
    end
    n_tests++;
    if ({ifB.dout, ifB.dout_valid} !== {32'h0000005A, 1'b1}) begin
      n_fail++; $display("FAIL rdw_new: got %h/%b want 0000005a/1", ifB.dout, ifB.dout_valid);
    end
    n_tests++;
    rdA(8'h20); rdB(8'h20); issue_and_wait();
    if ({ifA.dout, ifB.dout} !== {8'h5A, 32'h0000005A}) begin
      n_fail++; $display("FAIL rdw_after: got %h/%h want 5a/0000005a", ifA.dout, ifB.dout);
    end
    n_tests++;
  endtask

  task automatic test_out_of_range();
    wrB(8'h00, 32'h12345678, 4'hF); step();
    wrB(8'hC7, 32'h0BADCAFE, 4'hF); step();
    wrB(8'hF0, 32'hCAFEF00D, 4'hF); step();
    wrB(8'hC8, 32'hDEADBEEF, 4'hF); rdB(8'hF0); issue_and_wait();
    if ({ifB.dout, ifB.dout_valid} !== {32'h0, 1'b1}) begin
      n_fail++; $display("FAIL oor_read: got %h/%b want 0/1", ifB.dout, ifB.dout_valid);
    end
    n_tests++;
    rdB(8'h00); issue_and_wait();
    if ({ifB.dout, ifB.dout_valid} !== {32'h12345678, 1'b1}) begin
      n_fail++; $display("FAIL oor_word0: got %h/%b want 12345678/1", ifB.dout, ifB.dout_valid);
    end
    n_tests++;
    rdB(8'hC7); issue_and_wait();
    if (ifB.dout !== 32'h0BADCAFE) begin
      n_fail++; $display("FAIL last_word: got %h want 0badcafe", ifB.dout);
    end
    n_tests++;
    rdB(8'hC8); issue_and_wait();
    if ({ifB.dout, ifB.dout_valid} !== {32'h0, 1'b1}) begin
      n_fail++; $display("FAIL depth_boundary: got %h/%b want 0/1", ifB.dout, ifB.dout_valid);
    end
    n_tests++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ifA.wr_cs = 1'($urandom); ifA.we = 1'($urandom); ifA.be = 1'($urandom);
      ifA.wr_address = 8'($urandom_range(0, 7)); ifA.din = 8'($urandom);
      ifA.rd_cs = 1'($urandom); ifA.oe = 1'($urandom_range(0, 3) != 0);
      ifA.rd_address = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      ifB.wr_cs = 1'($urandom); ifB.we = 1'($urandom); ifB.be = 4'($urandom);
      ifB.wr_address = 8'($urandom_range(194, 205)); ifB.din = $urandom;
      ifB.rd_cs = 1'($urandom); ifB.oe = 1'($urandom_range(0, 3) != 0);
      ifB.rd_address = ($urandom_range(0, 3) == 0) ? ifB.wr_address : 8'($urandom_range(194, 205));
      step();
      if ({ifA.dout, ifA.dout_valid, ifA.ready} !== {dA[LAT-1][7:0], vA[LAT-1], rdyA}) begin
        n_fail++; $display("FAIL random_A cyc %0d: got %h/%b/%b want %h/%b/%b", i,
                           ifA.dout, ifA.dout_valid, ifA.ready, dA[LAT-1][7:0], vA[LAT-1], rdyA);
      end
      n_tests++;
      if ({ifB.dout, ifB.dout_valid, ifB.ready} !== {dB[LAT-1], vB[LAT-1], rdyB}) begin
        n_fail++; $display("FAIL random_B cyc %0d: got %h/%b/%b want %h/%b/%b", i,
                           ifB.dout, ifB.dout_valid, ifB.ready, dB[LAT-1], vB[LAT-1], rdyB);
      end
      n_tests++;
    end
    idle();
  endtask

  task automatic test_reset_midclear();
    // Mid-run reset with a valid, nonzero read result on the outputs.
    wrB(8'h05, 32'h89ABCDEF, 4'hF); step(); idle();
    rdB(8'h05); rdA(8'h10); repeat (LAT) step();
    rst = 1; model_reset();
    #1;
    if ({ifA.dout, ifA.dout_valid, ifA.ready, ifB.dout, ifB.dout_valid, ifB.ready} !== 44'b0) begin
      n_fail++; $display("FAIL reset_midrun: got A %h/%b/%b B %h/%b/%b want all 0",
                         ifA.dout, ifA.dout_valid, ifA.ready, ifB.dout, ifB.dout_valid, ifB.ready);
    end
    n_tests++;
    idle();
    @(posedge clk); #1; rst = 0;
    for (int k = 1; k <= 100; k++) begin
      wrA(8'($urandom_range(0, 15)), 8'($urandom_range(1, 255))); rdA(8'($urandom_range(0, 15)));
      step();
      if ({ifA.ready, ifA.dout_valid} !== 2'b00) begin
        n_fail++; $display("FAIL clear_ignore %0d: got rdy=%b v=%b want 0/0", k, ifA.ready, ifA.dout_valid);
      end
      n_tests++;
    end
    rst = 1; model_reset();
    #1;
    if ({ifA.dout, ifA.dout_valid, ifA.ready, ifB.ready} !== 11'b0) begin
      n_fail++; $display("FAIL reset_midclear: got %h/%b/%b/%b want 0", ifA.dout, ifA.dout_valid, ifA.ready, ifB.ready);
    end
    n_tests++;
    @(posedge clk); #1; rst = 0;
    for (int k = 1; k <= DA; k++) begin
      wrA(8'($urandom_range(0, 15)), 8'($urandom_range(1, 255))); rdA(8'($urandom_range(0, 15)));
      step();
      if ({ifA.ready, ifA.dout_valid, ifB.ready} !== {k >= DA, 1'b0, k >= DB}) begin
        n_fail++; $display("FAIL reclear %0d: got rdyA=%b vA=%b rdyB=%b want %b/0/%b",
                           k, ifA.ready, ifA.dout_valid, ifB.ready, k >= DA, k >= DB);
      end
      n_tests++;
    end
    idle();
    for (int a = 0; a < 16; a++) begin
      rdA(8'(a)); issue_and_wait();
      if ({ifA.dout, ifA.dout_valid} !== {8'h00, 1'b1}) begin
        n_fail++; $display("FAIL clear_writes_dropped %0d: got %h/%b want 00/1", a, ifA.dout, ifA.dout_valid);
      end
      n_tests++;
    end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_clear_readback();
    test_write_read();
    test_byte_lanes();
    test_rdw();
    test_out_of_range();
    test_random();
    test_reset_midclear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dualportram_sync.md
# dualportram_sync

Parametrised simple dual-port synchronous RAM, successor to the single-port block RAM: one write port and one read port operate in the same cycle. It adds per-byte write enables, configurable read-during-write behaviour, a read-valid strobe, address range checking, and a post-reset clear sequencer that zeroes every word before accepting traffic. It sits wherever the design needs on-chip buffering with concurrent producer and consumer.

## Interface
- DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 8, address bus width.
- DEPTH, 2**ADDRESS_WIDTH, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDRESS_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- RDW_MODE, 0, read-during-write to the same address: 0 = old data, 1 = new data (forwarded).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_cs  in  1  write port select.
- we  in  1  write enable.
- be  in  DATA_WIDTH/BYTE_WIDTH  byte lane enables; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_address  in  ADDRESS_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- rd_cs  in  1  read port select.
- oe  in  1  read enable.
- rd_address  in  ADDRESS_WIDTH  read address.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle strobe, dout carries a new read result.
- ready  out  1  clear complete; ports accept traffic.

## Operation
- Clear FSM states: CLEAR, RUN. rst → CLEAR, clear counter = 0.
- CLEAR: each cycle writes all-zero to word[counter], counter++. When counter == DEPTH-1 is written, next state RUN. While in CLEAR, ready = 0, user writes and reads are ignored, dout_valid = 0.
- RUN: ready = 1; stays in RUN until rst.
- Write: edge with ready && wr_cs && we updates enabled byte lanes at wr_address; disabled lanes retain contents. be = 0 is a no-op.
- Read: edge with ready && rd_cs && oe captures word[rd_address] into dout and pulses dout_valid.
- No read accepted: dout holds previous value, dout_valid = 0.
- Out of range (address ≥ DEPTH): write dropped; read returns all-zero with dout_valid = 1.
- Same-address read and write on one edge: RDW_MODE 0 → dout = pre-write word; RDW_MODE 1 → dout = merge (enabled lanes from din, others from old word).
- Different addresses on one edge: fully independent.

## Timing
- Reset values: dout = 0, dout_valid = 0, ready = 0, FSM = CLEAR, counter = 0.
- Clear duration: exactly DEPTH cycles; ready rises on the DEPTH-th rising edge after rst deasserts.
- rst asserted mid-clear or mid-run: outputs return to reset values immediately; clear restarts from address 0.
- Read latency: 1 cycle (dout/dout_valid update on the edge that samples the request). Full throughput on both ports, one access per port per cycle.
- Write is visible to a read of the same address on the following edge regardless of RDW_MODE.

## Configuration
- DUALPORTRAM_SYNC_OUTREG_EN defined: adds an output pipeline register. Read latency becomes 2 cycles, and dout_valid is delayed to stay aligned. The register resets to 0. A rst flushes any in-flight read.
- Undefined: latency 1 as above.

## Structure
- Package dualportram_sync_pkg holds:
  - the FSM state enum (CLEAR, RUN);
  - RDW_MODE constants RDW_OLD = 0 and RDW_NEW = 1;
  - a function returning the lane count (DATA_WIDTH/BYTE_WIDTH).
- One sub-module, dualportram_clear_fsm. It owns the state, the counter and ready, and outputs the clear write address and clear write strobe. The top level muxes the clear write with the user write port.

## Test plan
- Reset release, DEPTH = 256: ready = 0 for 255 edges and rises on edge 256. Reading all 256 addresses returns 0x00.
- Write 0xA5 to address 0x10, then read 0x10 on the next cycle: dout = 0xA5 with dout_valid one cycle later. With OUTREG_EN the result arrives two cycles later.
- DATA_WIDTH = 32, word = 0x11223344, write din = 0xAABBCCDD with be = 4'b0101: read returns 0x11BB33DD.
- Same-edge write of 0x5A and read at address 0x20, old value 0x00: RDW_MODE 0 → dout = 0x00; RDW_MODE 1 → dout = 0x5A.
- DEPTH = 200, ADDRESS_WIDTH = 8: a write to 0xF0 is dropped. A read of 0xF0 gives 0x00 with valid = 1, and word 0x00 is unchanged.
- Assert rst at clear counter = 100: outputs go to 0 at once. After release, ready rises exactly DEPTH cycles later, and requests issued during CLEAR produce no dout_valid.
